// File: rtl/cluster_clock_gate_ctrl_pkg.sv
// Shared types and defaults for the cluster clock-gate controller.
package cluster_cg_pkg;

    localparam int CG_CNT_W       = 8;
    localparam int CG_WAKE_CYCLES = 4;

    typedef enum logic [2:0] {
        ACTIVE,
        IDLE,
        DRAIN,
        GATED,
        WAKE
    } cg_state_e;

endpackage

// File: rtl/cluster_clock_gate_ctrl_if.sv
// Signal bundle between the clock-gate controller and the cluster / event unit.
interface cluster_clock_gate_ctrl_if
    import cluster_cg_pkg::*;
#(
    parameter int CNT_W = CG_CNT_W
) ();

    logic             busy_i;
    logic             wake_req_i;
    logic             force_en_i;
    logic [CNT_W-1:0] idle_thresh_i;
    logic             drain_ack_i;
    logic             drain_req_o;
    logic             clk_en_o;
    logic             gated_o;
    logic             wake_ack_o;

    // Controller side: consumes cluster status, drives the gate enable.
    modport master (
        input  busy_i,
        input  wake_req_i,
        input  force_en_i,
        input  idle_thresh_i,
        input  drain_ack_i,
        output drain_req_o,
        output clk_en_o,
        output gated_o,
        output wake_ack_o
    );

    // Cluster / event-unit side.
    modport slave (
        output busy_i,
        output wake_req_i,
        output force_en_i,
        output idle_thresh_i,
        output drain_ack_i,
        input  drain_req_o,
        input  clk_en_o,
        input  gated_o,
        input  wake_ack_o
    );

endinterface

// File: rtl/cluster_clock_gate_ctrl_idle_counter.sv
// Saturating idle-cycle counter with clear, load-to-one and threshold compare.
module cg_idle_counter
    import cluster_cg_pkg::*;
#(
    parameter int CNT_W = CG_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] thr_i,
    output logic             eq_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, then increment (held at all-ones), then clear.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(1);
        end else if (inc_i) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (clr_i) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign eq_o = (cnt_q == thr_i);

endmodule

// File: rtl/cluster_clock_gate_ctrl.sv
// Idle-detection FSM driving the cluster clock-gate enable, with drain
// handshake before gating and a fixed settle window after wake.
module cluster_clock_gate_ctrl
    import cluster_cg_pkg::*;
#(
    parameter int CNT_W       = CG_CNT_W,
    parameter int WAKE_CYCLES = CG_WAKE_CYCLES
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    cluster_clock_gate_ctrl_if.master bus
);

    // Settle counter runs 0..WAKE_CYCLES; WAKE_CYCLES is at most 15.
    localparam logic [3:0] SETTLE_LAST = 4'(WAKE_CYCLES);

    cg_state_e        state_q, state_d;
    logic [3:0]       settle_q, settle_d;
    logic [CNT_W-1:0] thr_q, thr_d;
    logic             clk_en_q, clk_en_d;
    logic             drain_req_q, drain_req_d;
    logic             gated_q, gated_d;
    logic             wake_ack_q, wake_ack_d;

    logic             wake_ev;
    logic             cnt_clr;
    logic             cnt_load;
    logic             cnt_inc;
    logic             cnt_eq;

    assign wake_ev = bus.busy_i | bus.wake_req_i | bus.force_en_i;

    cg_idle_counter #(
        .CNT_W (CNT_W)
    ) u_idle_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (cnt_clr),
        .load_i (cnt_load),
        .inc_i  (cnt_inc),
        .thr_i  (thr_q),
        .eq_o   (cnt_eq)
    );

    // Next-state, counter controls and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        thr_d    = thr_q;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;

        unique case (state_q)
            ACTIVE: begin
                cnt_clr = 1'b1;
                if (!wake_ev && (bus.idle_thresh_i != '0)) begin
                    state_d  = IDLE;
                    cnt_load = 1'b1;
                    thr_d    = bus.idle_thresh_i;
                end
            end
            IDLE: begin
                if (wake_ev) begin
                    state_d = ACTIVE;
                end else if (cnt_eq) begin
                    state_d = DRAIN;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DRAIN: begin
                // An abort takes priority over a simultaneous drain ack.
                if (wake_ev) begin
                    state_d = ACTIVE;
                end else if (bus.drain_ack_i) begin
                    state_d = GATED;
                end
            end
            GATED: begin
                if (wake_ev) begin
                    state_d  = WAKE;
                    settle_d = '0;
                end
            end
            WAKE: begin
                // Once entered, the settle window always completes.
                if (settle_q == SETTLE_LAST) begin
                    state_d = ACTIVE;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            default: begin
                state_d = ACTIVE;
            end
        endcase

        clk_en_d    = (state_d != GATED);
        drain_req_d = (state_d == DRAIN);
        gated_d     = (state_d == GATED);
        wake_ack_d  = (state_q == WAKE) && (state_d == WAKE) && (settle_d == SETTLE_LAST);
    end

    // State, settle counter, latched threshold and output registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ACTIVE;
            settle_q    <= '0;
            thr_q       <= '0;
            clk_en_q    <= 1'b1;
            drain_req_q <= 1'b0;
            gated_q     <= 1'b0;
            wake_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            thr_q       <= thr_d;
            clk_en_q    <= clk_en_d;
            drain_req_q <= drain_req_d;
            gated_q     <= gated_d;
            wake_ack_q  <= wake_ack_d;
        end
    end

    assign bus.clk_en_o    = clk_en_q;
    assign bus.drain_req_o = drain_req_q;
    assign bus.gated_o     = gated_q;
    assign bus.wake_ack_o  = wake_ack_q;

endmodule

// File: tb/tb_cluster_clock_gate_ctrl.sv
// Directed bench for cluster_clock_gate_ctrl (CNT_W=8, WAKE_CYCLES=4).
// Output nibble order in all expectations: {clk_en, drain_req, gated, wake_ack}.
module tb_cluster_clock_gate_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    cluster_clock_gate_ctrl_if #(.CNT_W(8)) bus ();

    cluster_clock_gate_ctrl #(
        .CNT_W       (8),
        .WAKE_CYCLES (4)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       busy;
        logic       wake;
        logic       fen;
        logic       ack;
        logic [7:0] thr;
        logic [3:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic b, input logic w, input logic f,
                                input logic a, input logic [7:0] t, input logic [3:0] e,
                                input string n);
        vec_t v;
        v.rst_n = r; v.busy = b; v.wake = w; v.fen = f; v.ack = a; v.thr = t; v.exp = e; v.name = n;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic r, input logic b, input logic w, input logic f,
                         input logic a, input logic [7:0] t);
        rst_n             = r;
        bus.busy_i        = b;
        bus.wake_req_i    = w;
        bus.force_en_i    = f;
        bus.drain_ack_i   = a;
        bus.idle_thresh_i = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] exp);
        logic [3:0] act;
        act = {bus.clk_en_o, bus.drain_req_o, bus.gated_o, bus.wake_ack_o};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: outputs %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3);

        // Each row: inputs held for one cycle; expected outputs after the edge.
        //   rst busy wake force ack thr   exp
        add(0, 1, 0, 0, 0, 8'd3, 4'b1000, "reset");
        add(1, 0, 0, 0, 0, 8'd3, 4'b1000, "active_to_idle");
        add(1, 0, 0, 0, 0, 8'd3, 4'b1000, "idle_cnt2");
        add(1, 0, 0, 0, 0, 8'd3, 4'b1000, "idle_cnt3");
        add(1, 0, 0, 0, 0, 8'd3, 4'b1100, "drain_cycle4");
        add(1, 0, 0, 0, 0, 8'd1, 4'b1100, "drain_hold_thr_change");
        add(1, 0, 0, 0, 0, 8'd3, 4'b1100, "drain_hold");
        add(1, 0, 0, 0, 1, 8'd3, 4'b0010, "gated_cycle7");
        add(1, 0, 0, 0, 0, 8'd3, 4'b0010, "gated_hold8");
        add(1, 0, 0, 0, 0, 8'd3, 4'b0010, "gated_hold9");
        add(1, 0, 0, 0, 0, 8'd3, 4'b0010, "gated_hold10");
        add(1, 0, 1, 0, 0, 8'd3, 4'b1000, "wake_en_cycle11");
        add(1, 0, 1, 0, 0, 8'd3, 4'b1000, "wake_settle12");
        add(1, 0, 1, 0, 0, 8'd3, 4'b1000, "wake_settle13");
        add(1, 0, 1, 0, 0, 8'd3, 4'b1000, "wake_settle14");
        add(1, 0, 1, 0, 0, 8'd3, 4'b1001, "wake_ack_cycle15");
        add(1, 0, 0, 0, 0, 8'd3, 4'b1000, "wake_ack_single");
        add(1, 0, 0, 0, 0, 8'd3, 4'b1000, "back_active_idle");
        add(1, 0, 0, 0, 0, 8'd3, 4'b1000, "idle2_cnt2");
        add(1, 0, 0, 0, 0, 8'd3, 4'b1000, "idle2_cnt3");
        add(1, 0, 0, 0, 0, 8'd3, 4'b1100, "drain2");
        add(1, 1, 0, 0, 1, 8'd3, 4'b1000, "abort_beats_ack");
        add(1, 0, 0, 0, 0, 8'd3, 4'b1000, "idle3_cnt1");
        add(1, 0, 0, 0, 0, 8'd0, 4'b1000, "idle3_thr0_ignored");
        add(1, 0, 0, 0, 0, 8'd0, 4'b1000, "idle3_cnt3");
        add(1, 0, 0, 0, 0, 8'd0, 4'b1100, "drain_latched_thr");
        add(1, 1, 0, 0, 0, 8'd0, 4'b1000, "busy_abort");

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].busy, vecs[i].wake, vecs[i].fen, vecs[i].ack, vecs[i].thr);
            tick();
            chk(vecs[i].name, vecs[i].exp);
        end

        // Threshold 0: gating disabled.
        drive(1, 0, 0, 0, 0, 8'd0);
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("thr0_stays_active", 4'b1000);
        end

        // Threshold 255 with a busy pulse after 200 idle cycles.
        drive(1, 0, 0, 0, 0, 8'd255);
        for (int i = 0; i < 200; i++) begin
            tick();
        end
        chk("thr255_no_drain_at_200", 4'b1000);
        drive(1, 1, 0, 0, 0, 8'd255);
        tick();
        chk("thr255_busy_pulse", 4'b1000);
        drive(1, 0, 0, 0, 0, 8'd255);
        for (int k = 1; k <= 256; k++) begin
            tick();
            chk((k == 256) ? "thr255_drain" : "thr255_counting", (k == 256) ? 4'b1100 : 4'b1000);
        end
        drive(1, 0, 0, 0, 1, 8'd255);
        tick();
        chk("thr255_gated", 4'b0010);

        // Reset while gated, then forced enable.
        drive(0, 0, 0, 0, 0, 8'd3);
        tick();
        chk("reset_from_gated", 4'b1000);
        drive(1, 0, 0, 1, 0, 8'd3);
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("force_en_active", 4'b1000);
        end

        // Short wake request; wake_ev drops and drain_ack is noise during WAKE.
        drive(1, 0, 0, 0, 0, 8'd1);
        tick();
        chk("thr1_idle", 4'b1000);
        tick();
        chk("thr1_drain", 4'b1100);
        drive(1, 0, 0, 0, 1, 8'd1);
        tick();
        chk("thr1_gated", 4'b0010);
        drive(1, 0, 1, 0, 0, 8'd1);
        tick();
        chk("pulse_wake_enter", 4'b1000);
        drive(1, 0, 0, 0, 1, 8'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("pulse_wake_settle", 4'b1000);
        end
        tick();
        chk("pulse_wake_ack", 4'b1001);
        drive(1, 1, 0, 0, 0, 8'd1);
        tick();
        chk("pulse_wake_done", 4'b1000);
        tick();
        chk("busy_holds_active", 4'b1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
